img_mem_writer: RTL and testbench
=================================

IMG_MEM_WRITER -- requirements
Module: img_mem_writer

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 262144, number of bytes per frame (range 1..262144).
REQ-002 SHALL have parameter BASE_ADDR, default 0, first memory address written (18-bit).
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a frame load.
REQ-006 SHALL have port abort  input  1  cancel the frame in progress.
REQ-007 SHALL have port s_data  input  8  pixel byte from upstream.
REQ-008 SHALL have port s_valid  input  1  s_data is valid.
REQ-009 SHALL have port s_ready  output  1  block accepts s_data this cycle.
REQ-010 SHALL have port mem_address  output  18  write address to image memory (0..262143).
REQ-011 SHALL have port mem_data  output  8  write data to image memory.
REQ-012 SHALL have port mem_we  output  1  write strobe, one byte per asserted cycle.
REQ-013 SHALL have port busy  output  1  frame load in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse, frame fully written.
REQ-015 SHALL have port checksum  output  8  running byte sum of the current or last frame.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, FINISH.
REQ-017 IDLE: s_ready=0, busy=0; start=1 -> LOAD, address counter <= BASE_ADDR, beat counter <= 0.
REQ-018 LOAD: s_ready=1, busy=1; beat accepted when s_valid & s_ready on a rising edge.
REQ-019 Each accepted beat SHALL produce, on the next cycle, mem_we=1, mem_data=beat byte, mem_address=current address counter (fixed 1-cycle latency, registered outputs).
REQ-020 mem_we SHALL be 0 on every cycle without a beat accepted the cycle before.
REQ-021 Address counter SHALL increment by 1 per accepted beat, modulo 2^18 (BASE_ADDR+FRAME_LEN > 262144 wraps to 0).
REQ-022 On acceptance of beat number FRAME_LEN, s_ready SHALL drop on the following cycle and FSM -> FINISH; no further beat accepted in that frame.
REQ-023 FINISH: lasts exactly one cycle, done=1, busy=0, then IDLE; the final mem_we is on the same cycle as done.
REQ-024 start while in LOAD or FINISH SHALL be ignored.
REQ-025 abort=1 in LOAD SHALL return FSM to IDLE next cycle, no done pulse; a beat accepted on the abort cycle SHALL NOT be written.
REQ-026 abort and start asserted together in IDLE: abort wins, FSM stays IDLE.
REQ-027 s_valid gaps SHALL stall the counters without timeout; s_data ignored while s_valid=0.
REQ-028 FRAME_LEN=1: single beat -> one write, then FINISH.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, s_ready=0, mem_we=0, mem_address=0, mem_data=0, busy=0, done=0, checksum=0, counters=0.
REQ-030 Reset mid-LOAD SHALL abandon the frame; no write or done after rst_n deasserts until a new start.

Configuration
REQ-031 Macro WR_CHECKSUM_EN: when defined, checksum SHALL clear to 0 on start and add each accepted (written) byte modulo 256, holding its value after FINISH until the next start.
REQ-032 Without WR_CHECKSUM_EN, checksum SHALL be constant 0 and no accumulator logic SHALL exist.

Verification
REQ-033 FRAME_LEN=4, BASE_ADDR=0x10, start then bytes 0x01,0x02,0x03,0x04 back-to-back -> writes at 0x10..0x13 with those data, done one cycle after last accept, checksum=0x0A (macro on).
REQ-034 FRAME_LEN=3, s_valid toggling 1,0,0,1,0,1 -> exactly 3 writes, addresses consecutive, no mem_we on gap-following cycles.
REQ-035 FRAME_LEN=4, BASE_ADDR=0x3FFFE -> write addresses 0x3FFFE,0x3FFFF,0x00000,0x00001.
REQ-036 Abort after 2 of 4 beats -> 2 writes only, done never asserted, next start reloads from BASE_ADDR with checksum cleared.
REQ-037 rst_n low during beat 2 of 4 -> all outputs 0 immediately, no further mem_we; start after release loads full frame.
REQ-038 start pulsed again mid-frame and s_valid held after final beat -> ignored, exactly FRAME_LEN writes, single done pulse.

Source files
------------

// File: rtl/img_mem_writer.sv
// img_mem_writer: loads FRAME_LEN bytes into image memory from BASE_ADDR (wraps mod 2^18); WR_CHECKSUM_EN adds a byte-sum checksum.
// Latency: each accepted beat is written 1 cycle later; backpressure: s_ready high only in LOAD, drops after the last beat.
`timescale 1ns/1ps
module img_mem_writer #(
   parameter int          FRAME_LEN = 262144,
   parameter logic [17:0] BASE_ADDR = 18'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [17:0] mem_address,
   output logic [7:0]  mem_data,
   output logic        mem_we,
   output logic        busy,
   output logic        done,
   output logic [7:0]  checksum
);
   typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

   localparam logic [18:0] LAST_BEAT = 19'(FRAME_LEN - 1);

   state_t      state;
   logic [17:0] addr_cnt;
   logic [18:0] beat_cnt;
   logic        accept;
   logic        frame_go;

   // s_ready is only ever high in LOAD, so accept implies LOAD
   assign accept   = s_valid & s_ready;
   assign frame_go = (state == IDLE) & start & ~abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         s_ready     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_we      <= 1'b0;
         mem_address <= 18'd0;
         mem_data    <= 8'd0;
         addr_cnt    <= 18'd0;
         beat_cnt    <= 19'd0;
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_go) begin
                  state    <= LOAD;
                  s_ready  <= 1'b1;
                  busy     <= 1'b1;
                  addr_cnt <= BASE_ADDR;
                  beat_cnt <= 19'd0;
               end
            end
            LOAD: begin
               if (abort) begin
                  state   <= IDLE;
                  s_ready <= 1'b0;
                  busy    <= 1'b0;
               end else if (accept) begin
                  mem_we      <= 1'b1;
                  mem_data    <= s_data;
                  mem_address <= addr_cnt;
                  addr_cnt    <= addr_cnt + 18'd1;
                  beat_cnt    <= beat_cnt + 19'd1;
                  if (beat_cnt == LAST_BEAT) begin
                     state   <= FINISH;
                     s_ready <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end
            FINISH: state <= IDLE;
            default: begin
               state   <= IDLE;
               s_ready <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef WR_CHECKSUM_EN
   logic [7:0] sum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= 8'd0;
      end else if (frame_go) begin
         sum_q <= 8'd0;
      end else if (state == LOAD && accept && !abort) begin
         sum_q <= sum_q + s_data;
      end
   end

   assign checksum = sum_q;
`else
   assign checksum = 8'd0;
`endif

endmodule

// File: tb/tb_img_mem_writer.sv
// Bench for img_mem_writer: write scoreboard (address, data, cycle) plus inline handshake/done checks per scenario.
`timescale 1ns/1ps
module tb_img_mem_writer;
   localparam int          L    = 4;
   localparam logic [17:0] BASE = 18'h3FFFE;
`ifdef WR_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   typedef struct packed {
      logic [17:0] addr;
      logic [7:0]  data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start, abort, s_valid, s_ready, mem_we, busy, done;
   logic [7:0]  s_data, mem_data, checksum;
   logic [17:0] mem_address;

   logic        o_start, o_valid, o_ready, o_we, o_busy, o_done;
   logic [7:0]  o_data, o_mdata, o_sum;
   logic [17:0] o_addr;

   exp_t        q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_pass = 0;
   int          done_cnt = 0;
   int          cyc = 0;
   logic [17:0] exp_addr;
   logic [7:0]  exp_sum;
   int          exp_beats;
   bit          exp_load = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   img_mem_writer #(.FRAME_LEN(L), .BASE_ADDR(BASE)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we),
      .busy(busy), .done(done), .checksum(checksum)
   );

   img_mem_writer #(.FRAME_LEN(1), .BASE_ADDR(18'h10)) u_one (
      .clk(clk), .rst_n(rst_n), .start(o_start), .abort(1'b0),
      .s_data(o_data), .s_valid(o_valid), .s_ready(o_ready),
      .mem_address(o_addr), .mem_data(o_mdata), .mem_we(o_we),
      .busy(o_busy), .done(o_done), .checksum(o_sum)
   );

   // every write must match the next expected beat, including the cycle it lands on
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (mem_we) begin
         n_checks++;
         if (q.size() == 0) begin
            $display("FAIL unexpected_write addr=%h data=%h cyc=%0d (no write expected)", mem_address, mem_data, cyc);
         end else begin
            mon_e = q.pop_front();
            if (mem_address !== mon_e.addr || mem_data !== mon_e.data || cyc !== mon_e.cyc)
               $display("FAIL write got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                        mem_address, mem_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
            else
               n_pass++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start     = 1'b0;
      exp_load  = 1'b1;
      exp_addr  = BASE;
      exp_sum   = 8'h00;
      exp_beats = 0;
   endtask

   task automatic beat(input logic v, input logic [7:0] d);
      exp_t e;
      s_valid = v;
      s_data  = d;
      if (v && exp_load) begin
         e.addr = exp_addr;
         e.data = d;
         e.cyc  = cyc + 1;
         q.push_back(e);
         exp_addr  = exp_addr + 18'd1;
         exp_sum   = exp_sum + d;
         exp_beats = exp_beats + 1;
         if (exp_beats == L) exp_load = 1'b0;
      end
      tick();
   endtask

   task automatic test_reset();
      start = 0; abort = 0; s_valid = 0; s_data = 8'h00;
      o_start = 0; o_valid = 0; o_data = 8'h00;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({s_ready, mem_we, busy, done} !== 4'b0000)
         $display("FAIL reset_ctrl got rdy/we/busy/done=%b expected 0000", {s_ready, mem_we, busy, done});
      else n_pass++;
      n_checks++;
      if (mem_address !== 18'h0 || mem_data !== 8'h0 || checksum !== 8'h0)
         $display("FAIL reset_data got addr=%h data=%h sum=%h expected 0/0/0", mem_address, mem_data, checksum);
      else n_pass++;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      n_checks++;
      if (s_ready !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0)
         $display("FAIL idle_after_reset got rdy=%b busy=%b we=%b expected 0/0/0", s_ready, busy, mem_we);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int d0 = done_cnt;
      do_start();
      n_checks++;
      if (s_ready !== 1'b1 || busy !== 1'b1 || checksum !== 8'h00)
         $display("FAIL load_entry got rdy=%b busy=%b sum=%h expected 1/1/00", s_ready, busy, checksum);
      else n_pass++;
      beat(1'b1, 8'h01);
      beat(1'b1, 8'h02);
      start = 1'b1;
      beat(1'b1, 8'h03);
      start = 1'b0;
      beat(1'b1, 8'h04);
      s_data = 8'h55;
      n_checks++;
      if (done !== 1'b1 || mem_we !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0)
         $display("FAIL b2b_finish got done=%b we=%b busy=%b rdy=%b expected 1/1/0/0", done, mem_we, busy, s_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0)
         $display("FAIL b2b_idle got done=%b busy=%b rdy=%b expected 0/0/0", done, busy, s_ready);
      else n_pass++;
      repeat (4) beat(1'b1, 8'h77);
      s_valid = 1'b0;
      n_checks++;
      if (checksum !== (CK ? 8'h0A : 8'h00))
         $display("FAIL b2b_checksum got %h expected %h", checksum, (CK ? 8'h0A : 8'h00));
      else n_pass++;
      n_checks++;
      if (done_cnt - d0 !== 1 || q.size() !== 0)
         $display("FAIL b2b_counts got done=%0d pending=%0d expected 1/0", done_cnt - d0, q.size());
      else n_pass++;
   endtask

   task automatic test_gaps();
      bit [7:0] pat = 8'b1010_1001;
      do_start();
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin
            n_checks++;
            if (s_ready !== 1'b1 || busy !== 1'b1)
               $display("FAIL gap_stall got rdy=%b busy=%b expected 1/1", s_ready, busy);
            else n_pass++;
         end
         beat(pat[i], 8'h20 + 8'(i));
      end
      s_valid = 1'b0;
      n_checks++;
      if (done !== 1'b1 || mem_we !== 1'b1)
         $display("FAIL gap_done got done=%b we=%b expected 1/1", done, mem_we);
      else n_pass++;
      repeat (2) tick();
      n_checks++;
      if (q.size() !== 0 || checksum !== (CK ? exp_sum : 8'h00))
         $display("FAIL gap_end got pending=%0d sum=%h expected 0/%h", q.size(), checksum, (CK ? exp_sum : 8'h00));
      else n_pass++;
   endtask

   task automatic test_abort();
      int d0 = done_cnt;
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      n_checks++;
      if (s_ready !== 1'b0 || busy !== 1'b0)
         $display("FAIL abort_beats_start got rdy=%b busy=%b expected 0/0", s_ready, busy);
      else n_pass++;
      do_start();
      beat(1'b1, 8'h11);
      beat(1'b1, 8'h22);
      abort = 1'b1; s_valid = 1'b1; s_data = 8'h33;
      exp_load = 1'b0;
      tick();
      abort = 1'b0; s_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || s_ready !== 1'b0 || mem_we !== 1'b0)
         $display("FAIL abort_exit got busy=%b rdy=%b we=%b expected 0/0/0", busy, s_ready, mem_we);
      else n_pass++;
      repeat (3) tick();
      n_checks++;
      if (done_cnt !== d0 || checksum !== (CK ? 8'h33 : 8'h00))
         $display("FAIL abort_no_done got done=%0d sum=%h expected %0d/%h", done_cnt, checksum, d0, (CK ? 8'h33 : 8'h00));
      else n_pass++;
      do_start();
      n_checks++;
      if (checksum !== 8'h00 || s_ready !== 1'b1)
         $display("FAIL restart_clear got sum=%h rdy=%b expected 00/1", checksum, s_ready);
      else n_pass++;
      for (int i = 0; i < L; i++) beat(1'b1, 8'h40 + 8'(i));
      s_valid = 1'b0;
      tick();
      n_checks++;
      if (q.size() !== 0 || done_cnt !== d0 + 1 || checksum !== (CK ? exp_sum : 8'h00))
         $display("FAIL restart_frame got pending=%0d done=%0d sum=%h expected 0/%0d/%h",
                  q.size(), done_cnt, checksum, d0 + 1, (CK ? exp_sum : 8'h00));
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int d0 = done_cnt;
      do_start();
      beat(1'b1, 8'h61);
      s_valid = 1'b1; s_data = 8'h62;
      exp_load = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({s_ready, mem_we, busy, done} !== 4'b0000 || mem_address !== 18'h0 || mem_data !== 8'h0 || checksum !== 8'h0)
         $display("FAIL reset_mid got rdy/we/busy/done=%b addr=%h data=%h sum=%h expected all 0",
                  {s_ready, mem_we, busy, done}, mem_address, mem_data, checksum);
      else n_pass++;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      s_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done_cnt !== d0 || q.size() !== 0)
         $display("FAIL reset_abandon got busy=%b done=%0d pending=%0d expected 0/%0d/0", busy, done_cnt, q.size(), d0);
      else n_pass++;
      do_start();
      for (int i = 0; i < L; i++) beat(1'b1, 8'h90 + 8'(i));
      s_valid = 1'b0;
      tick();
      n_checks++;
      if (q.size() !== 0 || done_cnt !== d0 + 1)
         $display("FAIL reset_reload got pending=%0d done=%0d expected 0/%0d", q.size(), done_cnt, d0 + 1);
      else n_pass++;
   endtask

   task automatic test_frame_len1();
      o_start = 1'b1;
      tick();
      o_start = 1'b0;
      n_checks++;
      if (o_ready !== 1'b1 || o_busy !== 1'b1)
         $display("FAIL one_load got rdy=%b busy=%b expected 1/1", o_ready, o_busy);
      else n_pass++;
      o_valid = 1'b1; o_data = 8'hA5;
      tick();
      o_data = 8'h5A;
      n_checks++;
      if (o_we !== 1'b1 || o_addr !== 18'h10 || o_mdata !== 8'hA5 || o_done !== 1'b1 || o_busy !== 1'b0 || o_ready !== 1'b0)
         $display("FAIL one_write got we=%b addr=%h data=%h done=%b busy=%b rdy=%b expected 1/00010/a5/1/0/0",
                  o_we, o_addr, o_mdata, o_done, o_busy, o_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (o_we !== 1'b0 || o_done !== 1'b0 || o_sum !== (CK ? 8'hA5 : 8'h00))
         $display("FAIL one_after got we=%b done=%b sum=%h expected 0/0/%h", o_we, o_done, o_sum, (CK ? 8'hA5 : 8'h00));
      else n_pass++;
      o_valid = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gaps();
      test_abort();
      test_reset_mid();
      test_frame_len1();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
